// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling and a small
// valid/ready receive FIFO. Framing and overrun errors are one-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN (adds one even-parity bit after bit 7).
`timescale 1ns/1ps
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  // The counter runs from N-1 down to 0, so "expiry" lands exactly N cycles later.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic          rx_meta_q, rx_sync_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  logic expire, line, push, pop, full, empty, wr_en;

  assign expire = (cnt_q == '0);
  assign line   = rx_sync_q;

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive FSM next-state, bit assembly and error pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!line) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!expire) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!line) begin
          cnt_d   = FULL_M1;
          idx_d   = 4'd0;
          state_d = S_DATA;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!expire) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q[2:0]] = line;
          cnt_d = FULL_M1;
          if (idx_q == 4'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!expire) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_err_d = (^shift_q) ^ line;
          cnt_d     = FULL_M1;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!expire) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!line) begin
          ferr_d  = 1'b1;
          state_d = S_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
        end else if (par_err_q) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer arithmetic: pop is honoured first, so a full FIFO can accept a push while draining.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = !empty && ready_i;
    wr_en    = push && (!full || pop);
    ovr_d    = push && full && !pop;
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_en);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 4'd0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Datapath storage: shift register and FIFO array carry no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign valid_o     = !empty;
  assign data_o      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign busy_o      = (state_q != S_IDLE);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule
